// File: rtl/plic_gateway.sv
// Per-source interrupt gateway ahead of the PLIC core: synchronises raw interrupt
// wires, counts rising edges in edge mode and gates one outstanding request per source.
module plic_gateway #(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NUM_SRC:1]           SrcIn,
  input  logic [NUM_SRC:1]           EdgeMode,
  input  logic [NUM_SRC:1]           Claim,
  input  logic [NUM_SRC:1]           Complete,
  input  logic [NUM_SRC:1]           OvfClr,
  output logic [NUM_SRC:1]           Req,
  output logic [NUM_SRC:1]           Overflow,
  output logic [2*NUM_SRC-1:0]       o_dbg_state,
  output logic [CNT_W*NUM_SRC-1:0]   o_dbg_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_SRC:1] r_sync [SYNC_STAGES];
  logic [NUM_SRC:1] r_prev;
  logic [NUM_SRC:1] w_s;
  logic [NUM_SRC:1] w_edge;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= SrcIn;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_edge = w_s & ~r_prev & EdgeMode;

  // Handshake: Req is held while the source waits in REQ; a one-cycle Claim pulse
  // moves it to SERVICE, and a one-cycle Complete pulse in SERVICE returns it to IDLE.
  // Claim outside REQ and Complete outside SERVICE are ignored; Claim wins over Complete.
  for (genvar gi = 1; gi <= NUM_SRC; gi++) begin : g_src
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_req;
    logic             r_ovf;
    logic             w_dec;
    logic             w_inc;
    logic             w_ovf_set;

    always_comb begin
      w_next     = r_state;
      w_dec      = 1'b0;
      w_inc      = 1'b0;
      w_ovf_set  = 1'b0;
      w_cnt_next = r_cnt;
      case (r_state)
        S_IDLE: begin
          if (EdgeMode[gi] ? (r_cnt != '0 || w_edge[gi]) : w_s[gi]) begin
            w_next = S_REQ;
            w_dec  = EdgeMode[gi] && (r_cnt != '0);
          end
        end
        S_REQ: begin
          if (Claim[gi])                         w_next = S_SERVICE;
          else if (!EdgeMode[gi] && !w_s[gi])    w_next = S_IDLE;
        end
        S_SERVICE: begin
          if (Complete[gi]) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
      // An edge seen in IDLE with an empty counter is consumed by the move to REQ.
      w_inc = w_edge[gi] && !(r_state == S_IDLE && r_cnt == '0);
      if (!EdgeMode[gi]) begin
        w_cnt_next = '0;
      end else if (w_inc && !w_dec) begin
        if (r_cnt == CNT_MAX) w_ovf_set  = 1'b1;
        else                  w_cnt_next = r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        w_cnt_next = r_cnt - 1'b1;
      end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_req   <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        r_state <= w_next;
        r_cnt   <= w_cnt_next;
        r_req   <= (w_next == S_REQ);
        r_ovf   <= w_ovf_set | (r_ovf & ~OvfClr[gi]);
      end
    end

    assign Req[gi]                             = r_req;
    assign Overflow[gi]                        = r_ovf;
    assign o_dbg_state[2*(gi-1) +: 2]          = r_state;
    assign o_dbg_cnt[CNT_W*(gi-1) +: CNT_W]    = r_cnt;
  end

endmodule
